// File: rtl/sort5_seq.sv
// ============================================================================
// Module   : sort5_seq
// Brief    : Frame sequencer around the 5-word merge sorter: collects five
//            words, steps the sorter through its three phases, then streams
//            the sorted words back out smallest first.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sort5_seq #(
    parameter int DW = 16,
    parameter int NW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic [DW-1:0] srt_in1,
    output logic [DW-1:0] srt_in2,
    output logic [DW-1:0] srt_in3,
    output logic [DW-1:0] srt_in4,
    output logic [DW-1:0] srt_in5,
    output logic [1:0]    srt_mod,
    input  logic [DW-1:0] srt_out1,
    input  logic [DW-1:0] srt_out2,
    input  logic [DW-1:0] srt_out3,
    input  logic [DW-1:0] srt_out4,
    input  logic [DW-1:0] srt_out5
);

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_PH0     = 3'd1,
        S_PH1     = 3'd2,
        S_PH2     = 3'd3,
        S_CAP     = 3'd4,
        S_EMIT    = 3'd5
    } state_t;

    localparam logic [2:0] C_LAST_IDX = 3'(NW - 1);

    state_t        state_q, state_d;
    logic [2:0]    count_q, count_d;
    logic [2:0]    idx_q, idx_d;
    logic [DW-1:0] load_q [NW];
    logic [DW-1:0] cap_q  [NW];
    logic [DW-1:0] w_srt_out [NW];
    logic          w_accept;

    assign w_srt_out[0] = srt_out1;
    assign w_srt_out[1] = srt_out2;
    assign w_srt_out[2] = srt_out3;
    assign w_srt_out[3] = srt_out4;
    assign w_srt_out[4] = srt_out5;

    assign in_ready  = (state_q == S_COLLECT);
    assign busy      = (state_q != S_COLLECT);
    assign out_valid = (state_q == S_EMIT);
    assign out_last  = (state_q == S_EMIT) && (idx_q == C_LAST_IDX);
    assign out_data  = (state_q == S_EMIT) ? cap_q[idx_q] : '0;
    assign w_accept  = in_valid && in_ready;

    assign srt_in1 = load_q[0];
    assign srt_in2 = load_q[1];
    assign srt_in3 = load_q[2];
    assign srt_in4 = load_q[3];
    assign srt_in5 = load_q[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_COLLECT;
            count_q <= '0;
            idx_q   <= '0;
            for (int i = 0; i < NW; i++) begin
                load_q[i] <= '0;
                cap_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            if (w_accept) begin
                load_q[count_q] <= in_data;
            end
            // Sorter outputs settle after the mod=10 phase, i.e. during CAP.
            if (state_q == S_CAP) begin
                for (int i = 0; i < NW; i++) begin
                    cap_q[i] <= w_srt_out[i];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        srt_mod = 2'b11;
        case (state_q)
            S_COLLECT: begin
                if (w_accept) begin
                    if (count_q == C_LAST_IDX) begin
                        count_d = '0;
                        state_d = S_PH0;
                    end else begin
                        count_d = count_q + 3'd1;
                    end
                end
            end
            S_PH0: begin
                srt_mod = 2'b00;
                state_d = S_PH1;
            end
            S_PH1: begin
                srt_mod = 2'b01;
                state_d = S_PH2;
            end
            S_PH2: begin
                srt_mod = 2'b10;
                state_d = S_CAP;
            end
            S_CAP: begin
                state_d = S_EMIT;
                idx_d   = '0;
            end
            S_EMIT: begin
                if (out_ready) begin
                    if (idx_q == C_LAST_IDX) begin
                        state_d = S_COLLECT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/sort5_seq.md
Name: sort5_seq

Overview:
- Upstream/downstream sequencer wrapped around the team's 5-word merge sorter (mrge).
- Collects five 16-bit words from a valid/ready input stream and holds them on the sorter's in1..in5.
- Drives the sorter's mod control through its three phases (00, 01, 10) on consecutive cycles.
- Captures out1..out5 and streams them back out, smallest first, on a valid/ready output stream with a last marker.

Parameters:
- DW, 16, data word width; must equal the sorter word width.
- NW, 5, words per frame; fixed at 5; any other value is unsupported.

Ports:
- clk  input  1  rising-edge clock shared with the sorter
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input word valid
- in_ready  output  1  block can accept an input word
- in_data  input  DW  input word
- out_valid  output  1  output word valid
- out_ready  input  1  downstream accepts the output word
- out_data  output  DW  sorted output word
- out_last  output  1  high with the 5th (largest) word of a frame
- busy  output  1  high in any state other than COLLECT
- srt_in1..srt_in5  output  DW each  to sorter in1..in5
- srt_mod  output  2  to sorter mod
- srt_out1..srt_out5  input  DW each  from sorter out1..out5

Behaviour:
- Reset (rst high at a clk edge):
  - state <= COLLECT, word count <= 0.
  - load regs and capture regs <= 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_last=0, out_data=0, busy=0, srt_mod=2'b11, srt_in*=0.
  - Reset has priority over every other event in every state, including mid-phase and mid-emit. A partial frame is discarded.
- States: COLLECT, PH0, PH1, PH2, CAP, EMIT.
- srt_mod is decoded from state: PH0=00, PH1=01, PH2=10, all other states=11.
  - 11 is the sorter's no-op code, so its registers hold outside PH0..PH2.
- COLLECT:
  - in_ready=1.
  - On each in_valid&in_ready edge, word k (arrival order 0..4) is stored to load reg k+1 and count increments.
  - Gaps in in_valid are allowed.
  - On the edge accepting word 4: count <= 0, state <= PH0.
- srt_in1..5 are driven directly from the load regs.
  - Load regs change only in COLLECT, so they are stable through PH0..CAP.
- PH0 -> PH1 -> PH2 -> CAP: one cycle each, unconditional; in_ready=0.
  - The sorter samples mod=00 at the end of PH0, 01 at the end of PH1, and 10 at the end of PH2.
  - Its out1..out5 are therefore valid during CAP.
- CAP: capture regs <= srt_out1..5 at the end of CAP; state <= EMIT, idx <= 0.
- EMIT:
  - out_valid=1, out_data=capture[idx], out_last=(idx==4).
  - On out_valid&out_ready: idx increments.
  - When the handshake completes with idx==4: state <= COLLECT, out_valid <= 0.
  - out_data and out_last are held stable while out_ready is low.
- Latency:
  - The edge accepting the 5th input word is T.
  - out_valid rises after edge T+4.
  - Minimum frame turnaround is 5 input cycles + 4 + 5 output cycles.
- No overlap: in_ready=0 from PH0 through the final EMIT handshake. The next frame's first word is accepted no earlier than the cycle after the last output handshake.
- Output order is ascending, as produced by the sorter. Equal values pass through unchanged in count; duplicates are preserved.
- Word width: no arithmetic is performed; values 0 and 2^DW-1 pass unmodified.
- in_valid while in_ready=0 is ignored; the source must hold the word until in_ready.

Test Plan:
- Frame 5,4,3,2,1 with in_valid held high and out_ready=1 -> srt_mod sequence 11,00,01,10,11; outputs 1,2,3,4,5 on consecutive cycles; out_last only with 5; out_valid first high exactly 4 edges after the 5th accept.
- Frame 0xFFFF,0x0000,0x8000,0x0000,0x7FFF -> outputs 0x0000,0x0000,0x7FFF,0x8000,0xFFFF; duplicate zero is preserved.
- Frame 9,1,7,3,5 with out_ready toggling 1,0,0,1,0,1,... -> out_data and out_last stable across stalls; in_ready stays 0 until the 5th output handshake; outputs 1,3,5,7,9.
- in_valid asserted with random gaps across 5 words (e.g. 12,10,11,14,13), then an immediate back-to-back second frame 2,2,2,2,2 -> first frame yields 10..14; no second-frame word is accepted before the first frame's last handshake; second frame yields five 2s.
- Assert rst for 1 cycle after the 3rd input word, then again during EMIT after 2 outputs -> all outputs return to reset values on the next edge; srt_mod=11; a fresh frame 6,8,7,9,5 afterwards yields 5,6,7,8,9 with no stale data.
- in_valid held high during PH0..EMIT with changing in_data -> load regs unchanged (srt_in* stable); no word is accepted until COLLECT.
